// File: rtl/weight_bank_loader.sv
// rtl/weight_bank_loader.sv - double-buffered weight bank with single/burst loads and commit
module weight_bank_loader #(
    parameter int DATA_W    = 8,
    parameter int NUM_UNITS = 4,
    parameter int ADDR_W    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             dataIn,
    input  logic [ADDR_W-1:0]             address,
    input  logic                          write,
    input  logic                          burstStart,
    input  logic                          commit,
    input  logic [ADDR_W-1:0]             rdAddr,
    output logic [DATA_W-1:0]             rdData,
    output logic [NUM_UNITS*DATA_W-1:0]   weightsOut,
    output logic                          busy,
    output logic                          loadDone,
    output logic                          addrErr
);
    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [ADDR_W:0] NUM_L  = (ADDR_W+1)'(NUM_UNITS);
    localparam logic [ADDR_W:0] LAST_L = (ADDR_W+1)'(NUM_UNITS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] shadow_q [NUM_UNITS];
    logic [DATA_W-1:0] shadow_d [NUM_UNITS];
    logic [DATA_W-1:0] active_q [NUM_UNITS];
    logic [DATA_W-1:0] active_d [NUM_UNITS];
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              load_done_q, load_done_d;
    logic              addr_err_q, addr_err_d;

    logic [ADDR_W:0]   addr_ext, rd_ext, wr_idx;
    logic              addr_bad, wr_en;

    assign addr_ext = {1'b0, address};
    assign rd_ext   = {1'b0, rdAddr};
    assign addr_bad = (addr_ext >= NUM_L);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        rd_data_d   = '0;
        load_done_d = 1'b0;
        addr_err_d  = addr_err_q;
        wr_en       = 1'b0;
        wr_idx      = addr_ext;

        // Read-back sees the pre-write contents; out-of-range reads return zero.
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (rd_ext == (ADDR_W+1)'(i)) rd_data_d = shadow_q[i];
        end

        case (state_q)
            IDLE: begin
                if (burstStart) begin
                    state_d = BURST;
                    cnt_d   = '0;
                    ptr_d   = addr_bad ? '0 : addr_ext;
                    if (addr_bad) addr_err_d = 1'b1;
                end else if (write) begin
                    if (addr_bad) addr_err_d = 1'b1;
                    else          wr_en      = 1'b1;
                end
            end
            BURST: begin
                if (commit) pend_d = 1'b1;
                if (write) begin
                    wr_en  = 1'b1;
                    wr_idx = ptr_q;
                    ptr_d  = (ptr_q == LAST_L) ? '0 : ptr_q + 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_L) begin
                        state_d     = IDLE;
                        load_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < NUM_UNITS; i++) begin
            if (wr_en && wr_idx == (ADDR_W+1)'(i)) shadow_d[i] = dataIn;
        end

        // Copy from shadow_d so a same-cycle write (or final burst word) is included.
        if ((state_q == IDLE && commit) || (load_done_d && (pend_q || commit))) begin
            active_d = shadow_d;
            pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            shadow_q    <= '{default: '0};
            active_q    <= '{default: '0};
            rd_data_q   <= '0;
            load_done_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            rd_data_q   <= rd_data_d;
            load_done_q <= load_done_d;
            addr_err_q  <= addr_err_d;
        end
    end

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_out
        assign weightsOut[g*DATA_W +: DATA_W] = active_q[g];
    end

    assign rdData   = rd_data_q;
    assign busy     = (state_q == BURST);
    assign loadDone = load_done_q;
    assign addrErr  = addr_err_q;
endmodule

// File: tb/tb_weight_bank_loader.sv
// tb/tb_weight_bank_loader.sv - randomized check of weight_bank_loader (4- and 3-unit builds) against a reference model
module tb_weight_bank_loader;
    logic        clk = 1'b0;
    logic        reset, write, burstStart, commit;
    logic [7:0]  dataIn;
    logic [1:0]  address, rdAddr;
    logic [7:0]  rd4, rd3;
    logic [31:0] wo4;
    logic [23:0] wo3;
    logic        busy4, busy3, done4, done3, err4, err3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    weight_bank_loader #(.DATA_W(8), .NUM_UNITS(4), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset), .dataIn(dataIn), .address(address), .write(write),
        .burstStart(burstStart), .commit(commit), .rdAddr(rdAddr), .rdData(rd4),
        .weightsOut(wo4), .busy(busy4), .loadDone(done4), .addrErr(err4));

    weight_bank_loader #(.DATA_W(8), .NUM_UNITS(3), .ADDR_W(2)) dut3 (
        .clk(clk), .reset(reset), .dataIn(dataIn), .address(address), .write(write),
        .burstStart(burstStart), .commit(commit), .rdAddr(rdAddr), .rdData(rd3),
        .weightsOut(wo3), .busy(busy3), .loadDone(done3), .addrErr(err3));

    // Reference model: index m=0 is the 4-unit build, m=1 the 3-unit build.
    int       m_n   [2] = '{4, 3};
    bit [7:0] m_sh  [2][4];
    bit [7:0] m_act [2][4];
    bit       m_busy[2], m_pend[2], m_done[2], m_err[2];
    int       m_ptr [2], m_cnt[2];
    bit [7:0] m_rd  [2];

    task automatic model_step(input int m);
        bit [7:0] nsh [4];
        int n = m_n[m];
        nsh = m_sh[m];
        m_done[m] = 1'b0;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin m_sh[m][i] = 0; m_act[m][i] = 0; end
            m_busy[m] = 0; m_pend[m] = 0; m_err[m] = 0; m_ptr[m] = 0; m_cnt[m] = 0; m_rd[m] = 0;
            return;
        end
        m_rd[m] = (int'(rdAddr) < n) ? m_sh[m][rdAddr] : 8'h00;
        if (!m_busy[m]) begin
            if (burstStart) begin
                m_busy[m] = 1;
                m_cnt[m]  = 0;
                if (int'(address) >= n) begin m_ptr[m] = 0; m_err[m] = 1; end
                else m_ptr[m] = int'(address);
            end else if (write) begin
                if (int'(address) < n) nsh[address] = dataIn;
                else m_err[m] = 1;
            end
            if (commit) for (int i = 0; i < 4; i++) m_act[m][i] = nsh[i];
        end else begin
            if (commit) m_pend[m] = 1;
            if (write) begin
                nsh[m_ptr[m]] = dataIn;
                m_ptr[m] = (m_ptr[m] + 1) % n;
                m_cnt[m]++;
                if (m_cnt[m] == n) begin
                    m_busy[m] = 0;
                    m_done[m] = 1;
                    if (m_pend[m]) begin
                        for (int i = 0; i < 4; i++) m_act[m][i] = nsh[i];
                        m_pend[m] = 0;
                    end
                end
            end
        end
        m_sh[m] = nsh;
    endtask

    function automatic bit [31:0] packed_act(input int m);
        bit [31:0] v = 0;
        for (int i = 0; i < m_n[m]; i++) v[i*8 +: 8] = m_act[m][i];
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check("wout4", wo4, packed_act(0));
        check("rd4", {24'h0, rd4}, {24'h0, m_rd[0]});
        check("busy4", {31'h0, busy4}, {31'h0, m_busy[0]});
        check("done4", {31'h0, done4}, {31'h0, m_done[0]});
        check("err4", {31'h0, err4}, {31'h0, m_err[0]});
        check("wout3", {8'h0, wo3}, packed_act(1));
        check("rd3", {24'h0, rd3}, {24'h0, m_rd[1]});
        check("busy3", {31'h0, busy3}, {31'h0, m_busy[1]});
        check("done3", {31'h0, done3}, {31'h0, m_done[1]});
        check("err3", {31'h0, err3}, {31'h0, m_err[1]});
    endtask

    task automatic drive(input bit r, input bit bs, input bit w, input bit c,
                         input bit [1:0] a, input bit [7:0] d, input bit [1:0] ra);
        reset = r; burstStart = bs; write = w; commit = c;
        address = a; dataIn = d; rdAddr = ra;
        cycle();
    endtask

    task automatic idle(input bit [1:0] ra);
        drive(0, 0, 0, 0, 0, 0, ra);
    endtask

    initial begin
        reset = 1; burstStart = 0; write = 0; commit = 0; address = 0; dataIn = 0; rdAddr = 0;
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("rst_wout", wo4, 32'h0);

        // Single writes, read-back, commit.
        drive(0, 0, 1, 0, 0, 8'h11, 0);
        drive(0, 0, 1, 0, 1, 8'h22, 0);
        drive(0, 0, 1, 0, 2, 8'h33, 1);
        drive(0, 0, 1, 0, 3, 8'h44, 2);
        check("pre_commit", wo4, 32'h0);
        drive(0, 0, 0, 1, 0, 0, 3);
        check("post_commit", wo4, 32'h44332211);
        check("rd_addr3", {24'h0, rd4}, 32'h44);

        // Burst from 2 with gaps, commit mid-burst.
        drive(0, 1, 1, 0, 2, 8'hFF, 0);
        drive(0, 0, 1, 0, 0, 8'hA0, 0);
        idle(0);
        drive(0, 0, 1, 0, 3, 8'hA1, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 8'hA2, 0);
        check("mid_burst", wo4, 32'h44332211);
        idle(0);
        drive(0, 0, 1, 0, 0, 8'hA3, 1);
        check("burst_done", {31'h0, done4}, 32'h1);
        check("burst_wout", wo4, 32'hA1A0A3A2);
        idle(0);

        // Write forwarded into same-cycle commit.
        drive(0, 0, 1, 1, 1, 8'h5A, 0);
        check("fwd", {24'h0, wo4[15:8]}, 32'h5A);

        // Out-of-range on the 3-unit build.
        drive(0, 0, 1, 0, 3, 8'h77, 3);
        drive(0, 1, 0, 0, 3, 0, 0);
        drive(0, 0, 1, 0, 0, 8'hC0, 0);
        check("err3_sticky", {31'h0, err3}, 32'h1);
        drive(0, 0, 1, 0, 0, 8'hC1, 0);
        drive(0, 0, 1, 0, 0, 8'hC2, 0);

        // Reset after two burst words.
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 8'hB0, 0);
        drive(0, 0, 1, 0, 0, 8'hB1, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("rst_busy", {31'h0, busy4}, 32'h0);
        check("rst_err3", {31'h0, err3}, 32'h0);
        drive(0, 1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0, 8'hD0 + 8'(i), 0);
        check("fresh_burst", wo4, 32'h00000000);
        drive(0, 0, 0, 1, 0, 0, 0);
        check("fresh_commit", wo4, 32'hD2D1D0D3);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 149) == 0),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 6) == 0),
                  2'($urandom), 8'($urandom), 2'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
